// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receive stage with valid/ack holding register.
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   i_Rx_ClkTick       oversample square wave from the baud generator (rising edge = one sample enable)
//   i_Rx_Serial        asynchronous serial line, idle high
//   i_Rx_Ack           consumer acknowledge, honoured only while o_Rx_Valid is high
//   o_Rx_Data          last good received byte
//   o_Rx_Valid         holding register full, held until acknowledged
//   o_Frame_Err        one-cycle pulse when the stop bit samples low
//   o_Overrun          one-cycle pulse when a good byte replaces an unacknowledged one
//   o_Rx_Busy          receiver is inside a frame (any state but IDLE)
module uart_receiver #(
  parameter int DATA_BITS     = 8,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Rx_ClkTick,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ack,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Rx_Busy
);
  localparam int CW = $clog2(RX_OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(RX_OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 tick_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 rx_s, en, good;
  assign rx_s = sync_q[1];
  // one enable per rising edge of the oversample square wave
  assign en = i_Rx_ClkTick & ~tick_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    good    = 1'b0;
    ferr_d  = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          state_d = rx_s ? IDLE : START;
          cnt_d   = '0;
        end
        START: begin
          // mid-start-bit check rejects glitches shorter than half a bit
          cnt_d   = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
          bit_d   = '0;
          state_d = (cnt_q != HALF) ? START : rx_s ? IDLE : DATA;
        end
        DATA: begin
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bit_d   = bit_q + 1'b1;
            sh_d    = {rx_s, sh_q[DATA_BITS-1:1]};
            state_d = (bit_q == LAST_BIT) ? STOP : DATA;
          end
        end
        STOP: begin
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            good    = rx_s;
            ferr_d  = ~rx_s;
            state_d = rx_s ? IDLE : BREAK;
          end
        end
        BREAK:   state_d = rx_s ? IDLE : BREAK;
        default: state_d = IDLE;
      endcase
    end
  end
  // a completing byte wins over a same-cycle ack; overrun only if nobody took the old byte
  assign data_d  = good ? sh_q : data_q;
  assign valid_d = good | (valid_q & ~i_Rx_Ack);
  assign ovr_d   = good & valid_q & ~i_Rx_Ack;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      tick_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_Rx_Serial};
      tick_q  <= i_Rx_ClkTick;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign o_Rx_Data   = data_q;
  assign o_Rx_Valid  = valid_q;
  assign o_Frame_Err = ferr_q;
  assign o_Overrun   = ovr_q;
  assign o_Rx_Busy   = (state_q != IDLE);
endmodule
